// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flag register, ARMv4 condition check and enable gating.
// Optional macro COND_FLAG_PERF_CNT_EN adds saturating exec/skip counters.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   instr_valid       real instruction this cycle (0 = bubble)
//   cond              condition field [31:28]
//   flag_write        [1] load N,Z  [0] load C,V
//   alu_flags         {N,Z,C,V} from the ALU
//   pcs_in, reg_write_in, mem_write_in, no_write_in  decoder requests
//   pc_src, reg_write, mem_write  gated enables
//   cond_ex           condition passed (vs. pre-update flags)
//   flags             registered {N,Z,C,V}
//   exec_count, skip_count  perf counters (0 when feature disabled)
module cond_flag_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [3:0]       cond,
    input  logic [1:0]       flag_write,
    input  logic [3:0]       alu_flags,
    input  logic             pcs_in,
    input  logic             reg_write_in,
    input  logic             mem_write_in,
    input  logic             no_write_in,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       n_f;
    logic       z_f;
    logic       c_f;
    logic       v_f;
    logic       go;

    assign n_f = flags_q[3];
    assign z_f = flags_q[2];
    assign c_f = flags_q[1];
    assign v_f = flags_q[0];

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            4'h0: cond_ex = z_f;
            4'h1: cond_ex = !z_f;
            4'h2: cond_ex = c_f;
            4'h3: cond_ex = !c_f;
            4'h4: cond_ex = n_f;
            4'h5: cond_ex = !n_f;
            4'h6: cond_ex = v_f;
            4'h7: cond_ex = !v_f;
            4'h8: cond_ex = c_f && !z_f;
            4'h9: cond_ex = !c_f || z_f;
            4'ha: cond_ex = (n_f == v_f);
            4'hb: cond_ex = (n_f != v_f);
            4'hc: cond_ex = !z_f && (n_f == v_f);
            4'hd: cond_ex = z_f || (n_f != v_f);
            4'he: cond_ex = 1'b1;
            4'hf: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    // A bubble forces every enable low whatever the decoder drives.
    assign go        = instr_valid & cond_ex;
    assign pc_src    = go & pcs_in;
    assign reg_write = go & reg_write_in & !no_write_in;
    assign mem_write = go & mem_write_in;

    always_comb begin
        flags_d = flags_q;
        if (go) begin
            if (flag_write[1]) flags_d[3:2] = alu_flags[3:2];
            if (flag_write[0]) flags_d[1:0] = alu_flags[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= 4'b0000;
        else        flags_q <= flags_d;
    end

    assign flags = flags_q;

`ifdef COND_FLAG_PERF_CNT_EN
    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] exec_d;
    logic [CNT_W-1:0] skip_q;
    logic [CNT_W-1:0] skip_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        exec_d = exec_q;
        skip_d = skip_q;
        if (instr_valid && cond_ex && !(&exec_q))
            exec_d = exec_q + 1'b1;
        if (instr_valid && !cond_ex && !(&skip_q))
            skip_d = skip_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_q <= '0;
            skip_q <= '0;
        end else begin
            exec_q <= exec_d;
            skip_q <= skip_d;
        end
    end

    assign exec_count = exec_q;
    assign skip_count = skip_q;
`else
    assign exec_count = '0;
    assign skip_count = '0;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_cond_flag_unit;

`ifdef COND_FLAG_PERF_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic [3:0]    cond = 4'h0;
    logic [1:0]    flag_write = 2'b00;
    logic [3:0]    alu_flags = 4'h0;
    logic          pcs_in = 1'b0;
    logic          reg_write_in = 1'b0;
    logic          mem_write_in = 1'b0;
    logic          no_write_in = 1'b0;
    logic          pc_src;
    logic          reg_write;
    logic          mem_write;
    logic          cond_ex;
    logic [3:0]    flags;
    logic [CW-1:0] exec_count;
    logic [CW-1:0] skip_count;

    cond_flag_unit #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .cond         (cond),
        .flag_write   (flag_write),
        .alu_flags    (alu_flags),
        .pcs_in       (pcs_in),
        .reg_write_in (reg_write_in),
        .mem_write_in (mem_write_in),
        .no_write_in  (no_write_in),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .cond_ex      (cond_ex),
        .flags        (flags),
        .exec_count   (exec_count),
        .skip_count   (skip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          ce;
        logic          pc;
        logic          rw;
        logic          mw;
        logic [3:0]    fl;
        logic [CW-1:0] ec;
        logic [CW-1:0] sc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_exec = 0;
    int   n_skip = 0;

    function automatic logic [CW-1:0] sat(input int n);
        int mx;
        mx = (1 << CW) - 1;
        return (n > mx) ? mx[CW-1:0] : n[CW-1:0];
    endfunction

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h", nm, fld, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "cond_ex",    32'(cond_ex),    32'(e.ce));
            chk(e.name, "pc_src",     32'(pc_src),     32'(e.pc));
            chk(e.name, "reg_write",  32'(reg_write),  32'(e.rw));
            chk(e.name, "mem_write",  32'(mem_write),  32'(e.mw));
            chk(e.name, "flags",      32'(flags),      32'(e.fl));
            chk(e.name, "exec_count", 32'(exec_count), 32'(e.ec));
            chk(e.name, "skip_count", 32'(skip_count), 32'(e.sc));
        end
    end

    // Drive one cycle; ce/fl are hand-derived expected cond_ex and flags
    // seen during this cycle (before this vector's edge).
    task automatic step(input string nm, input logic v, input logic [3:0] c,
                        input logic [1:0] fw, input logic [3:0] alu,
                        input logic pcs, input logic rwi, input logic mwi,
                        input logic nwi, input logic ce, input logic [3:0] fl,
                        input logic pulse);
        exp_t e;
        @(posedge clk);
        #1;
        instr_valid  = v;
        cond         = c;
        flag_write   = fw;
        alu_flags    = alu;
        pcs_in       = pcs;
        reg_write_in = rwi;
        mem_write_in = mwi;
        no_write_in  = nwi;
        if (pulse) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
            n_exec = 0;
            n_skip = 0;
        end
        e.name = nm;
        e.ce   = ce;
        e.pc   = v & ce & pcs;
        e.rw   = v & ce & rwi & !nwi;
        e.mw   = v & ce & mwi;
        e.fl   = fl;
`ifdef COND_FLAG_PERF_CNT_EN
        e.ec   = sat(n_exec);
        e.sc   = sat(n_skip);
`else
        e.ec   = '0;
        e.sc   = '0;
`endif
        sb.push_back(e);
        if (v && ce)  n_exec++;
        if (v && !ce) n_skip++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] prev;
        logic [3:0] iv;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        step("rst_al",  1, 4'he, 2'b11, 4'b0100, 0,0,0,0, 1, 4'b0000, 0);
        step("eq",      1, 4'h0, 2'b00, 4'b0000, 0,0,0,0, 1, 4'b0100, 0);
        step("ne_fail", 1, 4'h1, 2'b11, 4'b1011, 1,1,1,0, 0, 4'b0100, 0);
        step("bubble",  0, 4'he, 2'b11, 4'b1111, 1,1,1,0, 1, 4'b0100, 0);
        step("clr",     1, 4'he, 2'b11, 4'b0000, 0,0,0,0, 1, 4'b0100, 0);
        step("cv_only", 1, 4'he, 2'b01, 4'b1111, 0,0,0,0, 1, 4'b0000, 0);
        step("nz_only", 1, 4'he, 2'b10, 4'b1000, 1,1,1,0, 1, 4'b0011, 0);
        step("set1001", 1, 4'he, 2'b11, 4'b1001, 0,0,0,0, 1, 4'b1011, 0);
        step("ge",      1, 4'ha, 2'b00, 4'b0000, 1,0,0,0, 1, 4'b1001, 0);
        step("lt",      1, 4'hb, 2'b00, 4'b0000, 1,0,0,0, 0, 4'b1001, 0);
        step("gt",      1, 4'hc, 2'b00, 4'b0000, 0,1,0,0, 1, 4'b1001, 0);
        step("le",      1, 4'hd, 2'b00, 4'b0000, 0,1,0,0, 0, 4'b1001, 0);
        step("hi",      1, 4'h8, 2'b00, 4'b0000, 0,0,1,0, 0, 4'b1001, 0);
        step("ls",      1, 4'h9, 2'b00, 4'b0000, 0,0,1,0, 1, 4'b1001, 0);
        step("mi",      1, 4'h4, 2'b00, 4'b0000, 1,1,1,0, 1, 4'b1001, 0);
        step("vs",      1, 4'h6, 2'b00, 4'b0000, 1,1,1,0, 1, 4'b1001, 0);
        step("cs",      1, 4'h2, 2'b00, 4'b0000, 1,1,1,0, 0, 4'b1001, 0);
        step("pl",      1, 4'h5, 2'b00, 4'b0000, 1,1,1,0, 0, 4'b1001, 0);

        prev = 4'b1001;
        for (int i = 0; i < 16; i++) begin
            iv = i[3:0];
            step("nv_set", 1, 4'he, 2'b11, iv,  0,0,0,0, 1, prev, 0);
            step("nv",     1, 4'hf, 2'b11, ~iv, 1,1,1,0, 0, iv,   0);
            prev = iv;
        end

        step("cmp",     1, 4'he, 2'b11, 4'b0110, 0,1,0,1, 1, 4'b1111, 0);
        step("set1111", 1, 4'he, 2'b11, 4'b1111, 0,0,0,0, 1, 4'b0110, 0);
        step("rst_mid", 0, 4'he, 2'b00, 4'b0000, 0,0,0,0, 1, 4'b0000, 1);

        for (int i = 0; i < 5; i++)
            step("cnt_ex", 1, 4'he, 2'b00, 4'b0000, 0,0,0,0, 1, 4'b0000, 0);
        for (int i = 0; i < 2; i++)
            step("cnt_sk", 1, 4'hf, 2'b00, 4'b0000, 0,0,0,0, 0, 4'b0000, 0);
        step("cnt_end", 0, 4'hf, 2'b00, 4'b0000, 0,0,0,0, 0, 4'b0000, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard", "pending", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumes the N/Z/C/V flags produced by the datapath ALU and holds them in the architectural flag register (CPSR NZCV).
- Evaluates each instruction's 4-bit ARMv4 condition field against the stored flags.
- Gates the decoder's write/branch enables so that failed-condition instructions have no architectural effect.
- Sits between the main decoder and the register file/memory/PC logic of the single-cycle processor.

Parameters:
- CNT_W, 16, width of the optional saturating performance counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- instr_valid  input  1  current-cycle instruction is real; 0 = bubble (no enables, no flag update, no count).
- cond  input  4  instruction condition field, bits [31:28].
- flag_write  input  2  bit1 = update N,Z; bit0 = update C,V.
- alu_flags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- pcs_in  input  1  decoder branch/PC-write request.
- reg_write_in  input  1  decoder register-write request.
- mem_write_in  input  1  decoder memory-write request.
- no_write_in  input  1  compare-class op (CMP/CMN/TST/TEQ): suppress reg_write, flags still update.
- pc_src  output  1  gated PC-write enable.
- reg_write  output  1  gated register-write enable.
- mem_write  output  1  gated memory-write enable.
- cond_ex  output  1  condition passed for the current instruction (combinational).
- flags  output  4  registered {N,Z,C,V}.
- exec_count  output  CNT_W  instructions executed (feature only).
- skip_count  output  CNT_W  instructions skipped (feature only).

Behaviour:
- Reset (rst_n=0, asynchronous): flags=4'b0000, counters=0. Combinational outputs follow the inputs against flags=0000.
- cond_ex is combinational from cond and the registered flags (the flags before this instruction's update). Condition table:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0 (never executes)
- Gated enables, all combinational, zero latency:
  - pc_src = instr_valid & cond_ex & pcs_in
  - reg_write = instr_valid & cond_ex & reg_write_in & !no_write_in
  - mem_write = instr_valid & cond_ex & mem_write_in
- Flag update on the rising edge, only when instr_valid & cond_ex:
  - flag_write[1]=1 loads N,Z from alu_flags.
  - flag_write[0]=1 loads C,V from alu_flags.
  - The two halves are independent; otherwise the flags hold.
- A failed condition never changes flags, even with flag_write=11.
- Back-to-back flag-setting instructions: each sees the flags committed at the previous edge. There is no same-cycle forwarding.
- Reset asserted mid-instruction clears the flags immediately. The in-flight update is lost.
- Gated outputs never glitch high when instr_valid=0, regardless of other inputs.

Optional Feature:
- Macro COND_FLAG_PERF_CNT_EN.
- Defined:
  - exec_count increments each edge with instr_valid & cond_ex.
  - skip_count increments each edge with instr_valid & !cond_ex.
  - Both saturate at 2^CNT_W-1 (no wrap) and clear on reset.
- Undefined: no counter registers; exec_count and skip_count are tied to 0.

Test Plan:
- Reset then cond=E, flag_write=11, alu_flags=0100, instr_valid=1, one edge -> flags=0100; next cycle cond=0 (EQ) -> cond_ex=1; cond=1 (NE) -> cond_ex=0.
- flags=0100, cond=1, reg_write_in=1, mem_write_in=1, pcs_in=1, flag_write=11, alu_flags=1011 -> all gated outputs 0, flags stay 0100 after the edge.
- flag_write=01, alu_flags=1111 from flags=0000, cond=E -> flags=0011; then flag_write=10, alu_flags=1000 -> flags=1011.
- Condition sweep: flags 1001 (N=1,V=1) -> GE=1, LT=0, GT=1, LE=0, HI=0, LS=1; cond=F -> cond_ex=0 for all 16 flag values.
- CMP: no_write_in=1, reg_write_in=1, cond=E, flag_write=11, alu_flags=0110 -> reg_write=0, flags=0110.
- rst_n pulsed low mid-cycle with flags=1111 -> flags=0000 before the next edge. With COND_FLAG_PERF_CNT_EN and CNT_W=2: 5 executed instructions -> exec_count=3 (saturated); 2 skipped -> skip_count=2.
